// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one synchronous memory between the CPU datapath and a loader/debug port.
// Round-robin on ties, loader priority while the CPU is halted, bursts bounded by MAX_BURST while the other port waits.
module mem_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_halted,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat is any cycle where the owner holds req=1 while its gnt=1; the requester
  // keeps addr/we/wdata stable until that beat, and read data returns with rvalid one cycle later.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LD  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic             last_ld_q, last_ld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after;
  logic             cpu_beat, ld_beat, beat, burst_done;
  logic             cpu_rd_q, ld_rd_q;

  function automatic state_t pick(input logic c, input logic l, input logic halted,
                                  input logic last_ld);
    if (c && l)  return (halted || !last_ld) ? OWN_LD : OWN_CPU;
    else if (c)  return OWN_CPU;
    else if (l)  return OWN_LD;
    else         return IDLE;
  endfunction

  assign cpu_beat = (state_q == OWN_CPU) && cpu_req;
  assign ld_beat  = (state_q == OWN_LD) && ld_req;
  assign beat     = cpu_beat || ld_beat;

  // Burst limit looks at the count including this cycle's beat, so MAX_BURST beats then handoff.
  always_comb begin
    cnt_after = cnt_q;
    if (beat && (cnt_q != CNT_MAX)) cnt_after = cnt_q + CNT_W'(1);
  end
  assign burst_done = (cnt_after == CNT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = pick(cpu_req, ld_req, cpu_halted, last_ld_q);
      OWN_CPU: begin
        if (!cpu_req || (burst_done && ld_req)) state_d = ld_req ? OWN_LD : IDLE;
      end
      OWN_LD: begin
        if (burst_done && cpu_req && !cpu_halted) state_d = OWN_CPU;
        else if (!ld_req && !ld_lock)             state_d = cpu_req ? OWN_CPU : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_ld_d = last_ld_q;
    cnt_d     = cnt_after;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == OWN_LD)  last_ld_d = 1'b1;
      if (state_d == OWN_CPU) last_ld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_ld_q <= 1'b1;
      cnt_q     <= '0;
      cpu_rd_q  <= 1'b0;
      ld_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_ld_q <= last_ld_d;
      cnt_q     <= cnt_d;
      cpu_rd_q  <= cpu_beat && !cpu_we;
      ld_rd_q   <= ld_beat && !ld_we;
    end
  end

  always_comb begin
    mem_en    = beat;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_beat) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_beat) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign cpu_gnt    = (state_q == OWN_CPU);
  assign ld_gnt     = (state_q == OWN_LD);
  assign cpu_rvalid = cpu_rd_q;
  assign ld_rvalid  = ld_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_rdata : '0;
  assign ld_rdata   = ld_rd_q ? mem_rdata : '0;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random bench for mem_arbiter: a memory model, a shadow copy of memory
// feeding per-port expected read queues, and per-cycle checks of pins, grants and wait bounds.
module tb_mem_arbiter;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_halted = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_wdata = '0;
  logic              ld_gnt, ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] shadow [16];
  logic [DATA_W-1:0] cpu_exp_q [$];
  logic [DATA_W-1:0] ld_exp_q [$];
  logic              cpu_beat, ld_beat;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_halted(cpu_halted), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    if (i == 3) return 8'hA5;
    return 8'(32'h10 + i);
  endfunction

  // synchronous memory: read data one cycle after a read strobe
  logic [7:0] mem [16];
  logic [7:0] mem_rd_q;
  logic       mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rd_q <= mem[mem_addr];
    end
  end
  assign mem_rdata = mem_rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-cycle scoreboard, called at the falling edge
  task automatic observe();
    logic exp_v;
    logic [DATA_W-1:0] exp_d;
    cpu_beat = cpu_gnt && cpu_req;
    ld_beat  = ld_gnt && ld_req;
    chk("one_owner", 32'(cpu_gnt & ld_gnt), 0);
    exp_v = (cpu_exp_q.size() != 0);
    exp_d = '0;
    if (exp_v) exp_d = cpu_exp_q.pop_front();
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_v));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_d));
    exp_v = (ld_exp_q.size() != 0);
    exp_d = '0;
    if (exp_v) exp_d = ld_exp_q.pop_front();
    chk("ld_rvalid", 32'(ld_rvalid), 32'(exp_v));
    chk("ld_rdata", 32'(ld_rdata), 32'(exp_d));
    if (cpu_beat) begin
      chk("cpu_pins", {18'd0, mem_en, mem_we, mem_addr, 8'd0}, {18'd0, 1'b1, cpu_we, cpu_addr, 8'd0});
      if (cpu_we) begin
        chk("cpu_wdata", 32'(mem_wdata), 32'(cpu_wdata));
        shadow[cpu_addr] = cpu_wdata;
      end else cpu_exp_q.push_back(shadow[cpu_addr]);
    end else if (ld_beat) begin
      chk("ld_pins", {18'd0, mem_en, mem_we, mem_addr, 8'd0}, {18'd0, 1'b1, ld_we, ld_addr, 8'd0});
      if (ld_we) begin
        chk("ld_wdata", 32'(mem_wdata), 32'(ld_wdata));
        shadow[ld_addr] = ld_wdata;
      end else ld_exp_q.push_back(shadow[ld_addr]);
    end else begin
      chk("mem_idle", {18'd0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    end
    chk("busy_dbg", 32'(busy), 32'(dbg_state != 2'd0));
  endtask

  // loader write burst of 12 to addresses 0..11 under lock, CPU requesting a read
  task automatic ld_burst(input logic halted);
    int idx = 0, ld_n = 0, ld_first = -1, ld_last = -1, eighth = -1;
    int cpu_gnt_cyc = -1, ld_at_cpu = -1, cpu_gnts_during = 0, cpu_beats = 0;
    tick();
    cpu_halted = halted;
    ld_lock = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'd0; ld_wdata = 8'hC0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      observe();
      if (ld_beat) begin
        if (ld_n == 0) ld_first = c;
        ld_last = c;
        ld_n++;
        if (ld_n == MAX_BURST) eighth = c;
      end
      if (cpu_gnt && ld_n < 12) begin
        cpu_gnts_during++;
        if (cpu_gnt_cyc < 0) begin
          cpu_gnt_cyc = c;
          ld_at_cpu = ld_n;
        end
      end
      if (cpu_beat) cpu_beats++;
      tick();
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hE;
      end
      if (ld_beat) begin
        idx++;
        if (idx == 12) begin
          ld_req = 1'b0; ld_lock = 1'b0;
        end else begin
          ld_addr = 4'(idx); ld_wdata = 8'(8'hC0 + idx);
        end
      end
      if (cpu_beat) cpu_req = 1'b0;
    end
    chk("burst_ld_total", ld_n, 12);
    chk("burst_cpu_beats", cpu_beats, 1);
    chk("burst_idle_end", 32'(busy), 0);
    if (halted) begin
      chk("halt_no_cpu_gnt", cpu_gnts_during, 0);
      chk("halt_contiguous", ld_last - ld_first, 11);
    end else begin
      chk("burst_split_at", ld_at_cpu, MAX_BURST);
      chk("burst_handoff_lat", cpu_gnt_cyc - eighth, 1);
    end
    cpu_halted = 1'b0;
  endtask

  initial begin
    int cpu_wait, ld_wait;
    for (int i = 0; i < 16; i++) shadow[i] = pat(i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_gnt", {30'd0, cpu_gnt, ld_gnt}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem", {18'd0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_rvalid", {30'd0, cpu_rvalid, ld_rvalid}, 0);
    chk("rst_rdata", {16'd0, cpu_rdata, ld_rdata}, 0);
    tick();
    reset_n = 1'b1;

    // simultaneous first requests: CPU wins, loader follows
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'd2;
    @(negedge clk); observe();
    chk("tie_wait", {30'd0, cpu_gnt, ld_gnt}, 0);
    tick(); @(negedge clk); observe();
    chk("tie_cpu_first", {30'd0, cpu_gnt, ld_gnt}, 2);
    tick(); cpu_req = 1'b0;
    @(negedge clk); observe();
    chk("tie_ld_pending", 32'(ld_gnt), 0);
    tick(); @(negedge clk); observe();
    chk("tie_ld_next", 32'(ld_gnt), 1);
    tick(); ld_req = 1'b0;
    @(negedge clk); observe();
    tick(); @(negedge clk); observe();
    chk("tie_idle", 32'(busy), 0);

    // single CPU read of address 3
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    @(negedge clk); observe();
    chk("rd_no_gnt_yet", 32'(cpu_gnt), 0);
    tick(); @(negedge clk); observe();
    chk("rd_gnt", {28'd0, cpu_gnt, mem_en, mem_addr[1:0]}, {28'd0, 1'b1, 1'b1, 2'd3});
    tick(); cpu_req = 1'b0;
    @(negedge clk); observe();
    chk("rd_data", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'hA5});
    tick(); @(negedge clk); observe();
    chk("rd_idle", 32'(busy), 0);

    ld_burst(1'b0);
    ld_burst(1'b1);

    // locked loader with no request keeps ownership without beats
    tick();
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b1; ld_addr = 4'hF; ld_wdata = 8'h77;
    @(negedge clk); observe();
    tick(); @(negedge clk); observe();
    chk("lock_first_beat", 32'(ld_beat), 1);
    tick(); ld_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); observe();
      chk("lock_hold", {29'd0, ld_gnt, mem_en, busy}, {29'd0, 3'b101});
      tick();
    end
    ld_lock = 1'b0;
    @(negedge clk); observe();
    chk("lock_release_cyc", 32'(ld_gnt), 1);
    tick(); @(negedge clk); observe();
    chk("lock_idle", {30'd0, busy, ld_gnt}, 0);

    // reset during a loader burst with a read in flight
    tick();
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 1'b0; ld_addr = 4'd5;
    @(negedge clk); observe();
    tick(); @(negedge clk); observe();
    chk("mid_rst_beat", 32'(ld_beat), 1);
    tick();
    reset_n = 1'b0;
    cpu_exp_q.delete();
    ld_exp_q.delete();
    @(negedge clk);
    chk("mid_rst_gnt", {29'd0, cpu_gnt, ld_gnt, busy}, 0);
    chk("mid_rst_rvalid", {23'd0, ld_rvalid, ld_rdata}, 0);
    chk("mid_rst_mem", {18'd0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    tick();
    ld_req = 1'b0; ld_lock = 1'b0;
    @(negedge clk);
    chk("mid_rst_hold", {30'd0, ld_rvalid, busy}, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk); observe();
    chk("post_rst_idle", 32'(busy), 0);

    // random traffic on both ports, no lock, CPU running
    cpu_wait = 0;
    ld_wait = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); observe();
      if (cpu_req && !cpu_gnt) cpu_wait++; else cpu_wait = 0;
      if (ld_req && !ld_gnt) ld_wait++; else ld_wait = 0;
      chk("cpu_wait_bound", 32'(cpu_wait <= MAX_BURST + 1), 1);
      chk("ld_wait_bound", 32'(ld_wait <= MAX_BURST + 1), 1);
      tick();
      if ((cpu_beat && $urandom_range(0, 1) == 1) || (!cpu_req && $urandom_range(0, 2) == 0)) begin
        cpu_req = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 4'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom_range(0, 255));
      end else if (cpu_beat) cpu_req = 1'b0;
      if ((ld_beat && $urandom_range(0, 1) == 1) || (!ld_req && $urandom_range(0, 2) == 0)) begin
        ld_req = 1'b1;
        ld_we = 1'($urandom_range(0, 1));
        ld_addr = 4'($urandom_range(0, 15));
        ld_wdata = 8'($urandom_range(0, 255));
      end else if (ld_beat) ld_req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
